// File: rtl/tdm_demux.sv
// tdm_demux: locks onto frame_sync and steers interleaved samples into a
// double-buffered parallel frame word with a one-cycle frame_valid strobe.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      frame_valid,
  output logic                      locked,
  output logic                      sync_err
);
  localparam int SW = $clog2(CHANNELS);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t                    r_state, w_state;
  logic [SW-1:0]             r_slot, w_slot, w_idx;
  logic [CHANNELS*WIDTH-1:0] r_buf, w_buf, r_dout;
  logic                      r_fv, r_err, w_write, w_done, w_err;
  always_comb begin
    w_state = r_state;
    w_slot  = r_slot;
    w_idx   = r_slot;
    w_write = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        w_write = 1'b1;
        w_idx   = '0;
        w_slot  = SW'(1);
        w_state = LOCKED;
        w_err   = (r_state == LOCKED) && (r_slot != '0);
      end else if (r_state == LOCKED) begin
        if (r_slot == '0) begin
          w_err   = 1'b1;
          w_state = HUNT;
        end else begin
          w_write = 1'b1;
          w_done  = r_slot == SW'(CHANNELS-1);
          w_slot  = w_done ? '0 : r_slot + 1'b1;
        end
      end
    end
  end
  // Next buffer includes the current sample so the completing slot reaches dout on the same edge.
  always_comb begin
    w_buf = r_buf;
    for (int k = 0; k < CHANNELS; k++)
      if (w_write && w_idx == SW'(k)) w_buf[k*WIDTH +: WIDTH] = din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_slot  <= '0;
      r_buf   <= '0;
      r_dout  <= '0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_slot  <= w_slot;
      r_buf   <= w_buf;
      r_fv    <= w_done;
      r_err   <= w_err;
      if (w_done) r_dout <= w_buf;
    end
  end
  assign dout        = r_dout;
  assign frame_valid = r_fv;
  assign sync_err    = r_err;
  assign locked      = r_state == LOCKED;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for the 4-channel and 2-channel demux.
module tb_tdm_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0, din2 = '0;
  logic        dv = 1'b0, fs = 1'b0, dv2 = 1'b0, fs2 = 1'b0;
  logic [31:0] dout;
  logic [15:0] dout2;
  logic        fv, lk, err, fv2, lk2, err2;
  int          n_cmp = 0, n_bad = 0, fv_cnt = 0, err_cnt = 0;
  logic [31:0] q[$];
  logic [31:0] frm;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv), .frame_sync(fs),
    .dout(dout), .frame_valid(fv), .locked(lk), .sync_err(err));

  tdm_demux #(.WIDTH(8), .CHANNELS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(dv2), .frame_sync(fs2),
    .dout(dout2), .frame_valid(fv2), .locked(lk2), .sync_err(err2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    din = d;
    fs  = s;
    dv  = 1'b1;
    @(posedge clk);
    #1;
    dv  = 1'b0;
    fs  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (fv) begin
      fv_cnt++;
      chk("q_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("dout", dout, q.pop_front());
    end
    if (err) err_cnt++;
    if (fv || err) chk("fv_err_overlap", 32'(fv & err), 32'd0);
  end

  initial begin
    int f0, e0;
    #1;
    chk("rst_dout", dout, 32'd0);
    chk("rst_fv", 32'(fv), 32'd0);
    chk("rst_locked", 32'(lk), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // reset then lock
    send(8'h00, 1'b0);
    chk("hunt_locked", 32'(lk), 32'd0);
    send(8'h11, 1'b1);
    chk("lock_after_sync", 32'(lk), 32'd1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    q.push_back(32'h44332211);
    send(8'h44, 1'b0);
    settle();
    chk("t1_fv_cnt", 32'(fv_cnt), 32'd1);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // back-to-back frames with random gaps
    for (int f = 0; f < 3; f++) begin
      frm = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) begin
          f0 = fv_cnt;
          settle();
          chk("no_early_fv", 32'(fv_cnt), 32'(f0));
          q.push_back(frm);
        end
        send(frm[k*8 +: 8], k == 0);
        idle($urandom_range(0, 2));
      end
    end
    settle();
    chk("t2_fv_cnt", 32'(fv_cnt), 32'd4);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // early sync
    f0 = fv_cnt;
    e0 = err_cnt;
    send(8'hA0, 1'b1);
    send(8'hA1, 1'b0);
    send(8'hB0, 1'b1);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    q.push_back(32'hB3B2B1B0);
    send(8'hB3, 1'b0);
    settle();
    chk("early_err", 32'(err_cnt - e0), 32'd1);
    chk("early_fv", 32'(fv_cnt - f0), 32'd1);
    chk("early_locked", 32'(lk), 32'd1);

    // missing sync
    e0 = err_cnt;
    send(8'h77, 1'b0);
    settle();
    chk("miss_err", 32'(err_cnt - e0), 32'd1);
    chk("miss_locked", 32'(lk), 32'd0);
    chk("miss_dout_hold", dout, 32'hB3B2B1B0);
    send(8'h10, 1'b1);
    chk("relock", 32'(lk), 32'd1);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    q.push_back(32'h13121110);
    send(8'h13, 1'b0);

    // reset mid-frame
    send(8'hE0, 1'b1);
    send(8'hE1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 32'd0);
    chk("mid_rst_locked", 32'(lk), 32'd0);
    chk("mid_rst_fv", 32'(fv), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    idle(2);
    rst_n = 1'b1;
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    chk("post_rst_hunt", 32'(lk), 32'd0);
    f0 = fv_cnt;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    q.push_back(32'h04030201);
    send(8'h04, 1'b0);
    settle();
    chk("post_rst_fv", 32'(fv_cnt - f0), 32'd1);

    // CHANNELS=2 back-to-back
    dv2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din2 = (i % 2 == 0) ? 8'h5A : 8'hA5;
      fs2  = (i % 2 == 0);
      @(posedge clk);
      #1;
      chk("c2_fv", 32'(fv2), 32'(i % 2 == 1));
      chk("c2_locked", 32'(lk2), 32'd1);
      if (i % 2 == 1) chk("c2_dout", 32'(dout2), 32'h0000A55A);
    end
    dv2 = 1'b0;
    chk("c2_err", 32'(err2), 32'd0);

    idle(3);
    chk("q_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
